lbp: RTL and testbench
======================

Name: lbp

Overview:
- Local Binary Pattern engine for a 128x128 8-bit grayscale image held in an external host memory.
- Fetches pixels through a request/address read port and computes an 8-bit LBP code for every interior pixel.
- Writes each code to an external result memory through a valid/address/data write port, then asserts finish.

Parameters:
- IMG_W, 128, image width and height in pixels (square image).
- ADDR_W, 14, address width; log2(IMG_W*IMG_W).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- gray_ready  input  1  host image memory ready; no request may be issued while low.
- gray_req  output  1  read request qualifier for gray_addr.
- gray_addr  output  14  raster address of requested pixel, row*128+col.
- gray_data  input  8  pixel value returned by host.
- lbp_valid  output  1  write strobe for lbp_addr/lbp_data.
- lbp_addr  output  14  raster address of the result pixel.
- lbp_data  output  8  LBP code.
- finish  output  1  whole image processed.

Behaviour:
- Reset (async, active-high): all outputs 0, FSM to IDLE, window registers cleared; applies mid-operation, and processing restarts from pixel (1,1) after release.
- All outputs are registered.
- Read timing: gray_req/gray_addr change at posedge k; host drives gray_data from the falling edge of cycle k. DUT samples gray_data at posedge k+1. One request per cycle may be pipelined back-to-back.
- Write timing: lbp_valid/lbp_addr/lbp_data are driven from a posedge for exactly one cycle per result. The sink captures them on the following falling edge.
- LBP definition: for a centre gc at (r,c), the neighbours are g0=(r-1,c-1), g1=(r-1,c), g2=(r-1,c+1), g3=(r,c-1), g4=(r,c+1), g5=(r+1,c-1), g6=(r+1,c), g7=(r+1,c+1).
  - Bit p of the code = 1 iff gp >= gc (unsigned compare, equality sets the bit).
- Border pixels (row 0, row 127, col 0, col 127) have a result of 0. By default they are not written; the result memory is pre-cleared.
- Scan order: interior rows 1..126, cols 1..126, raster order.
- Data reuse: a 3x3 window of registers shifts left per column step.
  - First pixel of each row loads all 9 pixels.
  - Each further step fetches only the new right column (3 reads).
- Total runtime must be < 80,000 cycles after reset release (target about 49,000).
- FSM states:
  - IDLE: wait for gray_ready=1.
  - LOAD9: 9 reads for a row start.
  - LOAD3: 3 reads for a column step.
  - CALC: compare and pack the code.
  - WRITE: one-cycle lbp_valid pulse.
  - DONE.
- FSM transitions:
  - WRITE -> LOAD3 if col<126.
  - WRITE -> LOAD9 if col==126 and row<126.
  - WRITE -> DONE after (126,126).
  - CALC/WRITE may overlap the reads of the next step, as long as read/write timing is kept.
- gray_req is 1 only in cycles that carry a valid gray_addr. It is 0 in IDLE, CALC-only cycles and DONE.
- finish:
  - Rises no earlier than the cycle after the last lbp_valid pulse.
  - Stays 1 until reset.
  - In DONE, gray_req=0 and lbp_valid=0.
- If gray_ready drops mid-run, the DUT continues. gray_ready gates only the start from IDLE.
- lbp_addr is held stable while lbp_valid=0 (the value is don't-care).

Optional Feature:
- BORDER_WRITE_EN defined: DUT also writes lbp_data=0 for all 508 border addresses, each a one-cycle lbp_valid pulse, interleaved or grouped before finish. Total runtime limit is still < 80,000 cycles.
- Undefined: border addresses are never written; lbp_valid pulses exactly 15,876 times.

Test Plan:
- Uniform image, all pixels 0x64 -> every interior code 0xFF, border 0, exactly 15,876 lbp_valid pulses, then finish=1.
- All 0x64 except (64,64)=0x32:
  - (64,64)=0xFF.
  - (63,63)=0x7F.
  - (63,64)=0xBF.
  - (65,65)=0xFE.
  - All other interior pixels 0xFF.
- Column gradient, pixel=2*col -> every interior code 0xD6; rows/cols 0 and 127 remain 0.
- gray_ready held 0 for 20 cycles after reset -> gray_req stays 0 throughout; outputs are correct after gray_ready=1.
- Reset asserted asynchronously mid-run (e.g. cycle 10,000), then released:
  - All outputs go to 0 immediately.
  - The rerun produces the full correct image and finish within 80,000 cycles of release.
- Timing check:
  - Each sampled gray_data corresponds to the address driven in the previous cycle.
  - Each lbp_valid pulse lasts one cycle.
  - finish stays stable high after completion.

Source files
------------

// File: rtl/lbp.sv
// Local Binary Pattern engine: streams a square 8-bit image from host memory and writes one code per interior pixel.
// Optional BORDER_WRITE_EN: also writes a zero code to every border address before finish.
module lbp #(
    parameter int IMG_W  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [7:0]        gray_data,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              finish
);
    localparam int CW = ADDR_W / 2;
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 2);

    typedef enum logic [2:0] {IDLE, LOAD9, LOAD3, CALC, WRITE, BORDER, DONE} state_t;

    state_t            state_r;
    logic [CW-1:0]     row_r, col_r;
    logic [1:0]        dr_r, dc_r;
    logic              cap_vld_r, cap_last_r;
    logic [1:0]        cap_dr_r;
    logic [ADDR_W-1:0] cap_addr_r;
    logic [7:0]        stage_r [0:1];
    logic [7:0]        win_r [0:2][0:2];
    logic              calc_pend_r;
    logic [ADDR_W-1:0] calc_addr_r;
    logic [CW-1:0]     rd_row_s, rd_col_s;
    logic              step_end_s;
    logic [7:0]        code_s;
`ifdef BORDER_WRITE_EN
    localparam logic [CW-1:0] ZERO_C = CW'(0);
    localparam logic [CW-1:0] MAX_C  = CW'(IMG_W - 1);
    logic [CW-1:0]     br_r, bc_r;
`endif

    // Read address of the next pixel and detection of the final read of a window step
    always_comb begin
        rd_row_s   = row_r + {{(CW-2){1'b0}}, dr_r} - ONE_C;
        rd_col_s   = col_r + {{(CW-2){1'b0}}, dc_r} - ONE_C;
        step_end_s = 1'b0;
        if (dr_r == 2'd2) begin
            step_end_s = (state_r == LOAD3) || (dc_r == 2'd2);
        end else begin
            step_end_s = 1'b0;
        end
    end

    // Compare the eight neighbours against the window centre; win_r is indexed [column][row]
    always_comb begin
        code_s    = 8'd0;
        code_s[0] = win_r[0][0] >= win_r[1][1];
        code_s[1] = win_r[1][0] >= win_r[1][1];
        code_s[2] = win_r[2][0] >= win_r[1][1];
        code_s[3] = win_r[0][1] >= win_r[1][1];
        code_s[4] = win_r[2][1] >= win_r[1][1];
        code_s[5] = win_r[0][2] >= win_r[1][1];
        code_s[6] = win_r[1][2] >= win_r[1][1];
        code_s[7] = win_r[2][2] >= win_r[1][1];
    end

    // Read-issue FSM plus capture/compute/write pipeline running underneath it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            gray_req    <= 1'b0;
            gray_addr   <= {ADDR_W{1'b0}};
            lbp_valid   <= 1'b0;
            lbp_addr    <= {ADDR_W{1'b0}};
            lbp_data    <= 8'd0;
            finish      <= 1'b0;
            row_r       <= {CW{1'b0}};
            col_r       <= {CW{1'b0}};
            dr_r        <= 2'd0;
            dc_r        <= 2'd0;
            cap_vld_r   <= 1'b0;
            cap_last_r  <= 1'b0;
            cap_dr_r    <= 2'd0;
            cap_addr_r  <= {ADDR_W{1'b0}};
            stage_r[0]  <= 8'd0;
            stage_r[1]  <= 8'd0;
            calc_pend_r <= 1'b0;
            calc_addr_r <= {ADDR_W{1'b0}};
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_r[i][j] <= 8'd0;
                end
            end
`ifdef BORDER_WRITE_EN
            br_r        <= {CW{1'b0}};
            bc_r        <= {CW{1'b0}};
`endif
        end else begin
            // Pixels arrive one cycle after their request; a full column shifts the window left
            cap_vld_r <= 1'b0;
            if (cap_vld_r) begin
                if (cap_dr_r == 2'd2) begin
                    for (int j = 0; j < 3; j++) begin
                        win_r[0][j] <= win_r[1][j];
                        win_r[1][j] <= win_r[2][j];
                    end
                    win_r[2][0] <= stage_r[0];
                    win_r[2][1] <= stage_r[1];
                    win_r[2][2] <= gray_data;
                end else if (cap_dr_r == 2'd1) begin
                    stage_r[1] <= gray_data;
                end else begin
                    stage_r[0] <= gray_data;
                end
            end
            calc_pend_r <= cap_vld_r && cap_last_r;
            calc_addr_r <= cap_addr_r;
            if (calc_pend_r) begin
                lbp_valid <= 1'b1;
                lbp_data  <= code_s;
                lbp_addr  <= calc_addr_r;
            end else begin
                lbp_valid <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    gray_req <= 1'b0;
                    if (gray_ready) begin
                        state_r <= LOAD9;
                        row_r   <= ONE_C;
                        col_r   <= ONE_C;
                        dr_r    <= 2'd0;
                        dc_r    <= 2'd0;
                    end
                end
                LOAD9, LOAD3: begin
                    gray_req   <= 1'b1;
                    gray_addr  <= {rd_row_s, rd_col_s};
                    cap_vld_r  <= 1'b1;
                    cap_dr_r   <= dr_r;
                    cap_last_r <= step_end_s;
                    cap_addr_r <= {row_r, col_r};
                    if (dr_r != 2'd2) begin
                        dr_r <= dr_r + 2'd1;
                    end else begin
                        dr_r <= 2'd0;
                        if (!step_end_s) begin
                            dc_r <= dc_r + 2'd1;
                        end else if (col_r != LAST_C) begin
                            col_r   <= col_r + ONE_C;
                            dc_r    <= 2'd2;
                            state_r <= LOAD3;
                        end else if (row_r != LAST_C) begin
                            row_r   <= row_r + ONE_C;
                            col_r   <= ONE_C;
                            dc_r    <= 2'd0;
                            state_r <= LOAD9;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    gray_req <= 1'b0;
                    state_r  <= WRITE;
                end
                WRITE: begin
                    gray_req <= 1'b0;
`ifdef BORDER_WRITE_EN
                    state_r  <= BORDER;
                    br_r     <= ZERO_C;
                    bc_r     <= ZERO_C;
`else
                    state_r  <= DONE;
`endif
                end
`ifdef BORDER_WRITE_EN
                BORDER: begin
                    gray_req  <= 1'b0;
                    lbp_valid <= 1'b1;
                    lbp_addr  <= {br_r, bc_r};
                    lbp_data  <= 8'd0;
                    if (br_r == MAX_C && bc_r == MAX_C) begin
                        state_r <= DONE;
                    end else if (bc_r == MAX_C) begin
                        bc_r <= ZERO_C;
                        br_r <= br_r + ONE_C;
                    end else if (br_r == ZERO_C || br_r == MAX_C) begin
                        bc_r <= bc_r + ONE_C;
                    end else begin
                        bc_r <= MAX_C;
                    end
                end
`endif
                DONE: begin
                    gray_req <= 1'b0;
                    finish   <= 1'b1;
                end
                default: begin
                    gray_req <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lbp.sv
// Directed bench for lbp: host image memory and result memory models with hand-derived expected codes.
module tb_lbp;
    localparam int N    = 128;
    localparam int NPIX = N * N;
`ifdef BORDER_WRITE_EN
    localparam int EXP_PULSES = 16384;
    localparam int EXP_BORDER = 508;
`else
    localparam int EXP_PULSES = 15876;
    localparam int EXP_BORDER = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        gray_ready = 1'b0;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data = 8'd0;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;

    logic [7:0] img [0:NPIX-1];
    logic [7:0] res [0:NPIX-1];
    bit         wr  [0:NPIX-1];
    int total = 0;
    int bad = 0;
    int pulses = 0;
    int dups = 0;

    lbp dut (
        .clk(clk), .reset(reset), .gray_ready(gray_ready),
        .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
        .finish(finish)
    );

    always #5 clk = ~clk;

    // Host memory answers on the falling edge; result sink captures on the falling edge
    always @(negedge clk) begin
        if (gray_req) gray_data = img[gray_addr];
        if (lbp_valid && !reset) begin
            if (wr[lbp_addr]) dups++;
            wr[lbp_addr]  = 1'b1;
            res[lbp_addr] = lbp_data;
            pulses++;
        end
    end

    function automatic bit is_border(input int r, input int c);
        return (r == 0) || (c == 0) || (r == N-1) || (c == N-1);
    endfunction

    function automatic logic [7:0] exp_spike(input int r, input int c);
        if (is_border(r, c)) return 8'h00;
        if (r == 63 && c == 63) return 8'h7F;
        if (r == 63 && c == 64) return 8'hBF;
        if (r == 63 && c == 65) return 8'hDF;
        if (r == 64 && c == 63) return 8'hEF;
        if (r == 64 && c == 65) return 8'hF7;
        if (r == 65 && c == 63) return 8'hFB;
        if (r == 65 && c == 64) return 8'hFD;
        if (r == 65 && c == 65) return 8'hFE;
        return 8'hFF;
    endfunction

    task automatic clear_sink();
        for (int a = 0; a < NPIX; a++) begin
            wr[a]  = 1'b0;
            res[a] = 8'd0;
        end
        pulses = 0;
        dups   = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        total++;
        if ({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish} !== 38'd0) begin
            bad++;
            $display("FAIL %s: got req=%0b gaddr=%0d valid=%0b laddr=%0d data=%h finish=%0b want all 0",
                     tag, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        total++;
        if (gray_req !== 1'b0) begin bad++; $display("FAIL reset_gray_req: got %0b want 0", gray_req); end
        total++;
        if (finish !== 1'b0) begin bad++; $display("FAIL reset_finish: got %0b want 0", finish); end
    endtask

    task automatic test_ready_gate();
        for (int a = 0; a < NPIX; a++) img[a] = 8'h64;
        img[64*N + 64] = 8'h32;
        clear_sink();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (gray_req !== 1'b0) begin bad++; $display("FAIL ready_gate_req cycle %0d: got %0b want 0", i, gray_req); end
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL ready_gate_writes: got %0d want 0", pulses); end
        gray_ready = 1'b1;
    endtask

    // Partial run of the spike image through row 65, then an asynchronous reset
    task automatic test_spike_partial();
        int cyc = 0;
        int nbad = 0;
        int nmiss = 0;
        while (pulses < 8130 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (pulses < 8130) begin bad++; $display("FAIL spike_progress: got %0d writes want >=8130", pulses); end
        total++;
        if (res[63*N+63] !== 8'h7F) begin bad++; $display("FAIL spike_63_63: got %h want 7f", res[63*N+63]); end
        total++;
        if (res[63*N+64] !== 8'hBF) begin bad++; $display("FAIL spike_63_64: got %h want bf", res[63*N+64]); end
        total++;
        if (res[64*N+64] !== 8'hFF) begin bad++; $display("FAIL spike_64_64: got %h want ff", res[64*N+64]); end
        total++;
        if (res[65*N+65] !== 8'hFE) begin bad++; $display("FAIL spike_65_65: got %h want fe", res[65*N+65]); end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (wr[r*N+c] && res[r*N+c] !== exp_spike(r, c)) nbad++;
                if (r >= 1 && r <= 64 && !is_border(r, c) && !wr[r*N+c]) nmiss++;
            end
        end
        total++;
        if (nbad !== 0) begin bad++; $display("FAIL spike_codes: got %0d wrong codes want 0", nbad); end
        total++;
        if (nmiss !== 0) begin bad++; $display("FAIL spike_coverage: got %0d unwritten want 0", nmiss); end
        total++;
        if (dups !== 0) begin bad++; $display("FAIL spike_dups: got %0d want 0", dups); end
    endtask

    task automatic test_async_reset();
        #2 reset = 1'b1;
        #1 check_outputs_zero("async_reset");
        @(negedge clk);
        check_outputs_zero("reset_held");
    endtask

    // Full rerun on a column gradient; gray_ready drops shortly after start
    task automatic test_gradient_full();
        int cyc = 0;
        int nbad = 0;
        int nborder = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[r*N+c] = 8'(2*c);
        clear_sink();
        gray_ready = 1'b1;
        reset = 1'b0;
        while (finish !== 1'b1 && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 50) gray_ready = 1'b0;
        end
        total++;
        if (finish !== 1'b1) begin bad++; $display("FAIL grad_runtime: got finish=%0b after %0d cycles want 1", finish, cyc); end
        total++;
        if (pulses !== EXP_PULSES) begin bad++; $display("FAIL grad_pulses: got %0d want %0d", pulses, EXP_PULSES); end
        total++;
        if (dups !== 0) begin bad++; $display("FAIL grad_dups: got %0d want 0", dups); end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (is_border(r, c)) begin
                    if (wr[r*N+c]) nborder++;
                    if (res[r*N+c] !== 8'h00) nbad++;
                end else if (res[r*N+c] !== 8'hD6) begin
                    nbad++;
                end
            end
        end
        total++;
        if (nbad !== 0) begin bad++; $display("FAIL grad_codes: got %0d wrong codes want 0", nbad); end
        total++;
        if (nborder !== EXP_BORDER) begin bad++; $display("FAIL grad_border_writes: got %0d want %0d", nborder, EXP_BORDER); end
        total++;
        if (res[1*N+1] !== 8'hD6) begin bad++; $display("FAIL grad_1_1: got %h want d6", res[1*N+1]); end
        total++;
        if (res[126*N+126] !== 8'hD6) begin bad++; $display("FAIL grad_126_126: got %h want d6", res[126*N+126]); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({finish, gray_req, lbp_valid} !== 3'b100) begin
                bad++;
                $display("FAIL done_stable cycle %0d: got finish=%0b req=%0b valid=%0b want 1 0 0",
                         i, finish, gray_req, lbp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ready_gate();
        test_spike_partial();
        test_async_reset();
        test_gradient_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
